// File: rtl/rr_decod_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the decoder arbiter (slave).
interface rr_decod_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;

  modport master (output req, output done, input sel, input en, input gnt, input busy);
  modport slave  (input req, input done, output sel, output en, output gnt, output busy);
endinterface

// File: rtl/rr_decod_arbiter.sv
// Round-robin arbiter for the shared 3-to-8 decoder select path: one grantee at a time,
// bounded hold time, and one dead cycle between grants so decoded outputs never overlap.
module rr_decod_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  rr_decod_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_sel;
  logic [2:0]        r_ptr;
  logic              r_en;
  logic [7:0]        r_gnt;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic [7:0]        w_rot;
  logic [2:0]        w_offset;
  logic [2:0]        w_winner;
  logic              w_any_req;
  logic              w_release;
  logic              w_busy;

  // Requests rotated so that bit 0 is the requester at ptr (highest priority).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign w_rot[gi] = bus.req[r_ptr + 3'(gi)];
    end
  endgenerate

  always_comb begin
    w_offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) w_offset = 3'(k);
    end
  end

  assign w_winner  = r_ptr + w_offset;
  assign w_any_req = |bus.req;
  assign w_release = !bus.req[r_sel] || bus.done || (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_GRANT;
      S_GRANT: if (w_release) w_next_state = S_GAP;
      S_GAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // sel is deliberately left unchanged on release; only en/gnt drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= 3'd0;
      r_ptr      <= 3'd0;
      r_en       <= 1'b0;
      r_gnt      <= 8'h00;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel      <= w_winner;
            r_en       <= 1'b1;
            r_gnt      <= 8'b1 << w_winner;
            r_hold_cnt <= '0;
          end
        end
        S_GRANT: begin
          r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          if (w_release) begin
            r_en  <= 1'b0;
            r_gnt <= 8'h00;
            r_ptr <= r_sel + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel  = r_sel;
  assign bus.en   = r_en;
  assign bus.gnt  = r_gnt;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_rr_decod_arbiter.sv
// Scoreboard bench for rr_decod_arbiter: a cycle model queues expected outputs per
// driven cycle; directed scenarios add fixed-value checks on top.
module tb_rr_decod_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  rr_decod_arbiter_if bus ();

  rr_decod_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed as {busy, en, gnt[7:0], sel[2:0]}
  logic [12:0] exp_q[$];
  logic [12:0] obs;

  int         m_state;  // 0 idle, 1 grant, 2 gap
  int         m_sel;
  int         m_ptr;
  int         m_hold;
  logic       m_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_en    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, output logic [12:0] e);
    logic [7:0] g;
    bit found;
    case (m_state)
      0: begin
        if (r != 8'h00) begin
          found = 0;
          for (int k = 0; k < 8; k++) begin
            if (!found && r[(m_ptr + k) % 8]) begin
              m_sel = (m_ptr + k) % 8;
              found = 1;
            end
          end
          m_en    = 1'b1;
          m_hold  = 0;
          m_state = 1;
        end
      end
      1: begin
        if (!r[m_sel] || d || (m_hold == MAX_HOLD - 1)) begin
          m_en    = 1'b0;
          m_ptr   = (m_sel + 1) % 8;
          m_state = 2;
        end
        m_hold++;
      end
      default: m_state = 0;
    endcase
    g = m_en ? (8'h01 << m_sel) : 8'h00;
    e = {(m_state != 0), m_en, g, 3'(m_sel)};
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic d);
    logic [12:0] e;
    bus.req  = r;
    bus.done = d;
    model_step(r, d, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs = {bus.busy, bus.en, bus.gnt, bus.sel};
    if (exp_q.size() == 0) check({tag, "_qempty"}, 32'd1, 32'd0);
    else check(tag, 32'(obs), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("rst_out", 32'({bus.busy, bus.en, bus.gnt, bus.sel}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] en_seq;
  logic [6:0] busy_seq;

  initial begin
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // T1: asynchronous reset while requester 5 is granted
    step("t1_grant", 8'h20, 1'b0);
    check("t1_sel5", 32'(bus.sel), 32'd5);
    step("t1_hold", 8'h20, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("t1_async_sel",  32'(bus.sel),  32'd0);
    check("t1_async_en",   32'(bus.en),   32'd0);
    check("t1_async_gnt",  32'(bus.gnt),  32'd0);
    check("t1_async_busy", 32'(bus.busy), 32'd0);
    do_reset();

    // T2: single requester held high gets exactly MAX_HOLD enable cycles
    for (int i = 6; i >= 0; i--) begin
      step("t2", 8'h08, 1'b0);
      en_seq[i]   = bus.en;
      busy_seq[i] = bus.busy;
    end
    check("t2_sel",  32'(bus.sel), 32'd3);
    check("t2_gnt",  32'(bus.gnt), 32'h08);
    check("t2_en_seq",   32'(en_seq),   32'b1111001);
    check("t2_busy_seq", 32'(busy_seq), 32'b1111101);
    do_reset();

    // T3: all requesting, done in first grant cycle -> 0,1,...,7,0
    for (int g = 0; g < 9; g++) begin
      step("t3_grant", 8'hFF, 1'b0);
      check("t3_sel", 32'(bus.sel), 32'(g % 8));
      step("t3_done", 8'hFF, 1'b1);
      step("t3_gap", 8'hFF, 1'b0);
    end
    do_reset();

    // T4: early release of requester 7 by dropping its request
    step("t4_g6", 8'h40, 1'b0);
    step("t4_rel6", 8'h40, 1'b1);
    step("t4_gap", 8'h81, 1'b0);
    step("t4_g7", 8'h81, 1'b0);
    check("t4_sel7", 32'(bus.sel), 32'd7);
    step("t4_hold", 8'h81, 1'b0);
    step("t4_drop", 8'h01, 1'b0);
    check("t4_en_off", 32'({bus.busy, bus.en}), 32'b10);
    step("t4_gap2", 8'h81, 1'b0);
    step("t4_g0", 8'h81, 1'b0);
    check("t4_gnt0", 32'({bus.en, bus.gnt, bus.sel}), 32'({1'b1, 8'h01, 3'd0}));
    do_reset();

    // T5: done, request drop and hold limit all in the same cycle
    for (int i = 0; i < 4; i++) step("t5_hold", 8'h08, 1'b0);
    step("t5_rel", 8'h00, 1'b1);
    check("t5_gap", 32'({bus.busy, bus.en, bus.gnt}), 32'({1'b1, 1'b0, 8'h00}));
    step("t5_idle", 8'h18, 1'b0);
    check("t5_one_gap", 32'(bus.busy), 32'd0);
    step("t5_next", 8'h18, 1'b0);
    check("t5_ptr4", 32'(bus.sel), 32'd4);
    do_reset();

    // T6: random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      step("t6_rand", r, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
